// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl -- responder for the requester's memory protocol. It accepts one
// read or write at a time over req/ready/ack and runs it on an asynchronous
// SRAM with WAIT_CYCLES-long access windows.
//
// Optional feature: define SRAM_BYTE_EN to add per-byte write enables
// (req_be in, ram_be_n out). Without it every write is full-word and the
// board ties be_n low.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req, req_we         request strobe and direction (1 = write)
//   req_addr, req_wdata request address and write data, sampled on accept
//   req_be              byte enables (SRAM_BYTE_EN only)
//   ready               high in IDLE; accept happens on edge with req&ready
//   ack                 one-cycle completion pulse
//   rdata               last read result, held until the next read completes
//   ram_addr, ram_data  SRAM address and tristate data bus
//   ram_ce_n/oe_n/we_n  SRAM strobes, active-low
//   ram_be_n            SRAM byte enables, active-low (SRAM_BYTE_EN only)
// ---------------------------------------------------------------------------
module sram_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef SRAM_BYTE_EN
  input  logic [DATA_W/8-1:0] req_be,
  output logic [DATA_W/8-1:0] ram_be_n,
`endif
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] wdata_q;
  logic              drive;
`ifdef SRAM_BYTE_EN
  logic [DATA_W/8-1:0] be_q;
`endif

  // Control path: state, counter, address and read result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rdata    <= '0;
      ram_addr <= '0;
`ifdef SRAM_BYTE_EN
      be_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            ram_addr <= req_addr;
            cnt      <= CNT_LOAD;
`ifdef SRAM_BYTE_EN
            be_q     <= req_be;
`endif
            state    <= req_we ? WR_SETUP : READ;
          end
        end
        READ: begin
          // Data is sampled on the last edge of the oe_n window.
          if (cnt == 4'd0) begin
            rdata <= ram_data;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WR_SETUP: begin
          cnt   <= CNT_LOAD;
          state <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt == 4'd0) state <= WR_HOLD;
          else             cnt   <= cnt - 4'd1;
        end
        WR_HOLD: state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write data register: pure datapath, only loaded on accept
  always_ff @(posedge clk) begin
    if (state == IDLE && req && req_we) wdata_q <= req_wdata;
  end

  // Moore decode: every pin below depends on the state register alone, so
  // an async reset releases the bus in the same cycle.
  assign ready    = (state == IDLE);
  assign ack      = (state == DONE);
  assign ram_ce_n = (state == IDLE) || (state == DONE);
  assign ram_oe_n = (state != READ);
  assign ram_we_n = (state != WR_PULSE);

  // Drive spans setup..hold so data outlasts we_n by a full cycle; READ never
  // drives, keeping the bus free whenever oe_n is low.
  assign drive    = (state == WR_SETUP) || (state == WR_PULSE) || (state == WR_HOLD);
  assign ram_data = drive ? wdata_q : 'z;

`ifdef SRAM_BYTE_EN
  always_comb begin
    ram_be_n = '1;
    if (state == READ) ram_be_n = '0;
    else if (drive)    ram_be_n = ~be_q;
  end
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl -- directed bench for sram_ctrl with a small SRAM model and a
// scoreboard queue of expected acks (cycle and read data). Build with
// +define+SRAM_BYTE_EN to also exercise byte enables.
// ---------------------------------------------------------------------------
module tb_sram_ctrl;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int W  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_be_v = 4'hF;
  logic          ready, ack;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;
  logic          ram_ce_n, ram_oe_n, ram_we_n;
  logic [3:0]    be_n_w;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata),
`ifdef SRAM_BYTE_EN
    .req_be(req_be_v), .ram_be_n(be_n_w),
`endif
    .ready(ready), .ack(ack), .rdata(rdata), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n)
  );

`ifndef SRAM_BYTE_EN
  assign be_n_w = 4'b0000;
`endif

  // Undriven bus floats to all ones so release is observable.
  for (genvar i = 0; i < DW; i++) begin : g_pu
    pullup (ram_data[i]);
  end

  // SRAM model: 16 words decoded on ram_addr[3:0]; test addresses are
  // chosen with distinct low nibbles (0x12, 0x34, 0x56, 0xFFFFF, 0x00000).
  logic [DW-1:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = '0;
  assign ram_data = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr[3:0]] : 'z;
  always @(posedge clk) begin
    if (!ram_ce_n && !ram_we_n)
      for (int b = 0; b < 4; b++)
        if (!be_n_w[b]) mem[ram_addr[3:0]][8*b +: 8] <= ram_data[8*b +: 8];
  end

  typedef struct {
    bit            rd;
    logic [DW-1:0] data;
    int            at;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop one expectation per ack, compare timing and read data.
  always @(negedge clk) begin
    if (!rst) begin
      chk("oe_we_overlap", {63'd0, (!ram_oe_n && !ram_we_n)}, 64'd0);
      if (ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_cycle", 64'(cyc), 64'(e.at));
          if (e.rd) chk("rdata", 64'(rdata), 64'(e.data));
        end
      end
    end
  end

  // Wait for ready, present one request, return the accept cycle E0.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [3:0] be, input bit push, output int e0);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {63'd0, ready}, 64'd1);
    req = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be_v = be;
    @(posedge clk); #1;
    e0 = cyc;
    req = 1'b0;
    if (push) begin
      e.rd = !we; e.data = d; e.at = we ? e0 + W + 2 : e0 + W;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_we_low();
    int n;
    n = 0;
    @(negedge clk);
    while (ram_we_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("we_pulse_seen", {63'd0, ram_we_n}, 64'd0);
  endtask

  initial begin
    int e0, we_cnt, drv_cnt, oe_cnt;

    // Reset state before any clock edge
    #1;
    chk("rst_ce_n", {63'd0, ram_ce_n}, 64'd1);
    chk("rst_oe_n", {63'd0, ram_oe_n}, 64'd1);
    chk("rst_we_n", {63'd0, ram_we_n}, 64'd1);
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_ack", {63'd0, ack}, 64'd0);
    chk("rst_data_z", 64'(ram_data), 64'hFFFFFFFF);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_addr", 64'(ram_addr), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single write 0x00012 <= 0xDEADBEEF
    issue(1'b1, 20'h00012, 32'hDEADBEEF, 4'hF, 1'b1, e0);
    we_cnt = 0; drv_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) chk("wr_addr", 64'(ram_addr), 64'h12);
      if (!ram_we_n) we_cnt++;
      if (ram_data === 32'hDEADBEEF) drv_cnt++;
    end
    chk("wr_we_cycles", 64'(we_cnt), 64'd2);
    chk("wr_drive_cycles", 64'(drv_cnt), 64'd4);
    @(negedge clk);
    chk("wr_ready_back", 64'(cyc - e0), 64'd5);
    chk("wr_ready_val", {63'd0, ready}, 64'd1);

    // Single read of 0x00012
    issue(1'b0, 20'h00012, 32'hDEADBEEF, 4'hF, 1'b1, e0);
    oe_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (!ram_oe_n) oe_cnt++;
    end
    chk("rd_oe_cycles", 64'(oe_cnt), 64'd2);
    repeat (10) @(negedge clk);
    chk("rdata_hold", 64'(rdata), 64'hDEADBEEF);

    // Mid-cycle reset while idle: no clock edge between assert and check
    #2 rst = 1'b1;
    #1;
    chk("mrst_rdata", 64'(rdata), 64'd0);
    chk("mrst_addr", 64'(ram_addr), 64'd0);
    chk("mrst_ready", {63'd0, ready}, 64'd1);
    chk("mrst_ce_n", {63'd0, ram_ce_n}, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Busy: req pulsed during WR_PULSE must be ignored
    issue(1'b1, 20'h00034, 32'h55AA55AA, 4'hF, 1'b1, e0);
    wait_we_low();
    req = 1'b1; req_we = 1'b0; req_addr = 20'h00012;
    @(negedge clk);
    req = 1'b0;
    drain();

    // Back-to-back: req held, write 0xFFFFF then read it
    @(negedge clk);
    req = 1'b1; req_we = 1'b1; req_addr = 20'hFFFFF; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    e0 = cyc;
    sb.push_back('{rd: 1'b0, data: 32'h12345678, at: e0 + W + 2});
    sb.push_back('{rd: 1'b1, data: 32'h12345678, at: e0 + W + 4 + W});
    req_we = 1'b0;
    for (int k = 0; k < 12 && cyc < e0 + W + 4; k++) begin
      @(negedge clk);
      if (cyc == e0 + W + 3) chk("b2b_idle_ready", {63'd0, ready}, 64'd1);
    end
    req = 1'b0;
    drain();

    // Abort: reset during WR_PULSE, no ack expected
    issue(1'b1, 20'h00056, 32'h0BADF00D, 4'hF, 1'b0, e0);
    wait_we_low();
    #2 rst = 1'b1;
    #1;
    chk("abort_we_n", {63'd0, ram_we_n}, 64'd1);
    chk("abort_data_z", 64'(ram_data), 64'hFFFFFFFF);
    chk("abort_ack", {63'd0, ack}, 64'd0);
    chk("abort_ready", {63'd0, ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    drain();

`ifdef SRAM_BYTE_EN
    // Byte enables over a zeroed word at address 0
    issue(1'b1, 20'h00000, 32'h00000000, 4'hF, 1'b1, e0);
    issue(1'b1, 20'h00000, 32'hAABBCCDD, 4'b0101, 1'b1, e0);
    @(negedge clk);
    chk("be_n_write", 64'(be_n_w), 64'hA);
    drain();
    chk("be_n_idle", 64'(be_n_w), 64'hF);
    issue(1'b0, 20'h00000, 32'h00BB00DD, 4'hF, 1'b1, e0);
    @(negedge clk);
    chk("be_n_read", 64'(be_n_w), 64'h0);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
